tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-slot time-division demultiplexer. It is the receive end of the 4:1 select-driven mux path: a stream of beats, one per slot, is distributed to four registered outputs. A slot counter, re-aligned by a frame-sync marker, tracks the active select (s1,s0). All four outputs update together, once per completed frame.

## Interface
- WIDTH, 1, data width of each slot beat and of each output
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, asynchronous assert, active-low; release synchronous to clk
- din  input  WIDTH  slot beat data
- din_valid  input  1  din holds a beat this cycle
- frame_sync  input  1  marks the beat carrying slot 0; only meaningful when din_valid=1
- y0, y1, y2, y3  output  WIDTH  frame outputs, slots 0..3
- s1, s0  output  1 each  slot the next valid beat is assigned to (s1 is the MSB)
- locked  output  1  receiver is aligned to frame
- frame_valid  output  1  one-cycle pulse: y0..y3 were just updated
- sync_err  output  1  one-cycle pulse: a framing violation was detected

## Operation
- Reset values: all y = 0, s1 = s0 = 0, locked = 0, frame_valid = 0, sync_err = 0. The state is HUNT and the shadow registers are 0.
- There are two states: HUNT and LOCKED. The output locked equals (state == LOCKED).
- HUNT behaviour:
  - Beats are discarded until a beat arrives with din_valid=1 and frame_sync=1.
  - That beat is written to shadow0, the slot counter goes to 1, and the state goes to LOCKED.
- LOCKED behaviour:
  - Each valid beat is written to shadow[slot], and the slot counter increments modulo 4 (3 wraps to 0).
  - On the slot-3 beat, y0..y2 load from shadow0..2 and y3 loads from din, all on the same edge. frame_valid pulses.
  - The y outputs hold between frames. A partial frame never reaches y.
- din_valid=0 is a stall: the counter, shadows, and y all hold. frame_sync is ignored.
- The outputs {s1,s0} always equal the slot counter.
- A new frame may follow the slot-3 beat on the very next cycle. There are no bubbles between frames.

## Timing
- A beat sampled at edge N is committed at edge N.
- y0..y3 and frame_valid are visible after the edge that samples the slot-3 beat. Latency is 1 cycle from the slot-3 beat being presented.
- frame_valid is high for exactly 1 cycle per frame. With back-to-back frames at full rate it pulses every 4th cycle.
- sync_err is registered and high for exactly 1 cycle per violation.
- Asserting rst_n mid-frame clears immediately to the reset values. The partial frame is lost and frame_valid does not pulse.
- Minimum frame time is 4 cycles. There is no maximum, because stalls of any length are allowed.

## Configuration
- Macro: TDM_DEMUX4_SYNC_CHECK_EN.
- Behaviour when defined, in LOCKED:
  - A valid beat with frame_sync=1 at slot ≠ 0 pulses sync_err and discards the partial frame. The beat is taken as slot 0: shadow0 = din and the counter goes to 1. The state stays LOCKED.
  - A valid beat with frame_sync=0 at slot 0 pulses sync_err, discards the beat, and returns to HUNT with the counter at 0.
- Behaviour when undefined:
  - frame_sync is used only in HUNT. In LOCKED the counter free-runs on valid beats.
  - sync_err is tied to 0.

## Test plan
- Reset, then a frame with WIDTH=8: beats A1 (frame_sync=1), B2, C3, D4 on consecutive cycles. Required: y0..y3 = A1, B2, C3, D4 one cycle after the D4 beat; frame_valid pulses once; locked=1; {s1,s0} steps 1,2,3,0.
- Stall: same frame with din_valid=0 for 3 cycles between B2 and C3. Required: counter holds at 2 during the stall, the same y result, and frame_valid is delayed by 3 cycles.
- Back-to-back: 3 frames on 12 consecutive valid cycles, frame_sync only on beats 0, 4, 8. Required: frame_valid pulses at cycles 4, 8 and 12, and each y set matches its own frame.
- Misalignment with the macro defined: 2 beats, then frame_sync at slot 2. Required: sync_err pulses once, y is unchanged, and the new frame completes 4 beats later with the correct data.
  - With the macro undefined, the same stimulus requires no sync_err, and frame_valid pulses after 4 total beats.
- Reset mid-frame: assert rst_n low after the slot-2 beat. Required: all outputs 0 immediately, locked=0, and beats without frame_sync are ignored after release.
- Lost sync with the macro defined: a complete frame, then a slot-0 beat with frame_sync=0. Required: sync_err pulses and locked drops to 0. The y outputs keep the prior frame until the next frame_sync-led frame completes.

Source files
------------

// File: rtl/tdm_demux4.sv
// Four-slot TDM receiver: collects one beat per slot and publishes all four slots together.
// Optional frame-sync checking in the LOCKED state is enabled by TDM_DEMUX4_SYNC_CHECK_EN.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             s1,
    output logic             s0,
    output logic             locked,
    output logic             frame_valid,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q [3];
    logic [WIDTH-1:0] shadow_d [3];
    logic [WIDTH-1:0] y_q [4];
    logic [WIDTH-1:0] y_d [4];
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;
    logic             take_beat;

    always_comb begin
        // NOTE: every next-state signal gets a hold/idle default first, so no path infers a latch.
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        take_beat     = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
                    if (frame_sync && slot_q != 2'd0) begin
                        // Early marker: drop the partial frame and restart on this beat.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
                    end else if (!frame_sync && slot_q == 2'd0) begin
                        sync_err_d = 1'b1;
                        slot_d     = 2'd0;
                        state_d    = HUNT;
                    end else begin
                        take_beat = 1'b1;
                    end
`else
                    take_beat = 1'b1;
`endif
                end
                default: state_d = HUNT;
            endcase
        end

        if (take_beat) begin
            slot_d = slot_q + 2'd1;
            unique case (slot_q)
                2'd0: shadow_d[0] = din;
                2'd1: shadow_d[1] = din;
                2'd2: shadow_d[2] = din;
                default: begin
                    // Slot 3 goes straight to y3 so the whole frame lands on one edge.
                    y_d[0]        = shadow_q[0];
                    y_d[1]        = shadow_q[1];
                    y_d[2]        = shadow_q[2];
                    y_d[3]        = din;
                    frame_valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            // NOTE: the shadow array is small and explicitly reset, so no stale beat survives reset.
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
            for (int i = 0; i < 4; i++) y_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            state_q       <= state_d;
            slot_q        <= slot_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            shadow_q      <= shadow_d;
            y_q           <= y_d;
        end
    end

    assign y0          = y_q[0];
    assign y1          = y_q[1];
    assign y2          = y_q[2];
    assign y3          = y_q[3];
    assign s1          = slot_q[1];
    assign s0          = slot_q[0];
    assign locked      = (state_q == LOCKED);
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus random traffic against a
// queue-based frame model. Expectations follow TDM_DEMUX4_SYNC_CHECK_EN when it is defined.
module tb_tdm_demux4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;
    logic [W-1:0] y0, y1, y2, y3;
    logic         s1, s0, locked, frame_valid, sync_err;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .s1(s1), .s0(s0), .locked(locked),
        .frame_valid(frame_valid), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fv_seen = 0;
    int se_seen = 0;

    // Model: a frame is simply the list of beats collected since the last slot-0 beat.
    bit           m_locked;
    logic [W-1:0] m_beats[$];
    logic [W-1:0] m_y[4];
    bit           m_fv;
    bit           m_se;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        m_beats.delete();
        for (int i = 0; i < 4; i++) m_y[i] = '0;
        m_fv = 1'b0;
        m_se = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input bit fs, input logic [W-1:0] d);
        m_fv = 1'b0;
        m_se = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                m_beats.delete();
                m_beats.push_back(d);
            end
            return;
        end
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        if (fs && m_beats.size() != 0) begin
            m_se = 1'b1;
            m_beats.delete();
            m_beats.push_back(d);
            return;
        end
        if (!fs && m_beats.size() == 0) begin
            m_se = 1'b1;
            m_locked = 1'b0;
            return;
        end
`endif
        m_beats.push_back(d);
        if (m_beats.size() == 4) begin
            for (int i = 0; i < 4; i++) m_y[i] = m_beats[i];
            m_fv = 1'b1;
            m_beats.delete();
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_y0"}, 32'(y0), 32'(m_y[0]));
        check({tag, "_y1"}, 32'(y1), 32'(m_y[1]));
        check({tag, "_y2"}, 32'(y2), 32'(m_y[2]));
        check({tag, "_y3"}, 32'(y3), 32'(m_y[3]));
        check({tag, "_slot"}, 32'({s1, s0}), 32'(m_beats.size()));
        check({tag, "_locked"}, 32'(locked), 32'(m_locked));
        check({tag, "_fv"}, 32'(frame_valid), 32'(m_fv));
        check({tag, "_serr"}, 32'(sync_err), 32'(m_se));
        if (frame_valid === 1'b1) fv_seen++;
        if (sync_err === 1'b1) se_seen++;
    endtask

    task automatic beat(input string tag, input bit v, input bit fs, input logic [W-1:0] d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        model_step(v, fs, d);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        rst_n      = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int fv0;
        bit v, fs;
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = '0;
        model_reset();
        #1;
        compare_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic frame: slot steps 1,2,3,0 and y published one cycle after D4.
        beat("f1", 1, 1, 8'hA1);
        check("f1_s_after_a1", 32'({s1, s0}), 32'd1);
        beat("f1", 1, 0, 8'hB2);
        beat("f1", 1, 0, 8'hC3);
        check("f1_s_after_c3", 32'({s1, s0}), 32'd3);
        beat("f1", 1, 0, 8'hD4);
        check("f1_y", 32'({y0, y1, y2, y3}), 32'hA1B2C3D4);
        check("f1_fv", 32'(frame_valid), 32'd1);
        check("f1_locked", 32'(locked), 32'd1);
        beat("f1_idle", 0, 0, 8'h00);
        check("f1_fv_drop", 32'(frame_valid), 32'd0);

        // Stall between B2 and C3: slot holds at 2.
        beat("st", 1, 1, 8'h11);
        beat("st", 1, 0, 8'h22);
        for (int i = 0; i < 3; i++) begin
            beat("st_stall", 0, (i == 1), 8'hEE);
            check("st_slot_hold", 32'({s1, s0}), 32'd2);
        end
        beat("st", 1, 0, 8'h33);
        beat("st", 1, 0, 8'h44);
        check("st_y", 32'({y0, y1, y2, y3}), 32'h11223344);

        // Three back-to-back frames on 12 consecutive valid cycles.
        fv0 = fv_seen;
        for (int i = 0; i < 12; i++) begin
            beat("b2b", 1, (i % 4 == 0), W'(8'h50 + i));
            check("b2b_fv_phase", 32'(frame_valid), 32'(i % 4 == 3));
        end
        check("b2b_fv_count", 32'(fv_seen - fv0), 32'd3);
        check("b2b_last_y", 32'({y0, y1, y2, y3}), 32'h58595A5B);

        // Misaligned marker at slot 2.
        beat("mis", 1, 1, 8'h61);
        beat("mis", 1, 0, 8'h62);
        beat("mis", 1, 1, 8'h63);
        check("mis_y_unchanged", 32'({y0, y1, y2, y3}), 32'h58595A5B);
        beat("mis", 1, 0, 8'h64);
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        beat("mis", 1, 0, 8'h65);
        beat("mis", 1, 0, 8'h66);
        check("mis_y_new", 32'({y0, y1, y2, y3}), 32'h63646566);
`else
        check("mis_y_new", 32'({y0, y1, y2, y3}), 32'h61626364);
`endif
        check("mis_fv", 32'(frame_valid), 32'd1);

        // Reset after the slot-2 beat, then unsynced beats must be ignored.
        beat("rm", 1, 1, 8'h71);
        beat("rm", 1, 0, 8'h72);
        beat("rm", 1, 0, 8'h73);
        do_reset("rm_rst");
        check("rm_y_zero", 32'({y0, y1, y2, y3}), 32'h0);
        for (int i = 0; i < 4; i++) beat("rm_post", 1, 0, W'(8'h80 + i));
        check("rm_still_hunt", 32'(locked), 32'd0);

        // Lost sync: full frame, then a slot-0 beat without the marker.
        for (int i = 0; i < 4; i++) beat("ls", 1, (i == 0), W'(8'h90 + i));
        beat("ls_bad", 1, 0, 8'h9F);
`ifdef TDM_DEMUX4_SYNC_CHECK_EN
        check("ls_locked_drop", 32'(locked), 32'd0);
        check("ls_serr", 32'(sync_err), 32'd1);
`endif
        check("ls_y_kept", 32'({y0, y1, y2, y3}), 32'h90919293);
        for (int i = 0; i < 4; i++) beat("ls_re", 1, (i == 0), W'(8'hA0 + i));

        // Random traffic with stalls, stray markers and occasional resets.
        for (int n = 0; n < 800; n++) begin
            if (n % 211 == 210) do_reset("rnd_rst");
            v  = ($urandom_range(0, 3) != 0);
            fs = (m_beats.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
            beat("rnd", v, fs, W'($urandom));
        end
        check("rnd_frames_seen", 32'(fv_seen > 10), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
